// File: rtl/dcs_packet_pkg.sv
// Shared constants for the DCS packet blocks: arbiter FSM encoding and
// default payload width / transfer timeout.
package dcs_packet_pkg;

   typedef logic [1:0] dcs_state_t;

   localparam dcs_state_t StIdle  = 2'd0;
   localparam dcs_state_t StStart = 2'd1;
   localparam dcs_state_t StWait  = 2'd2;
   localparam dcs_state_t StDone  = 2'd3;

   localparam int DefDataWidth   = 20;
   localparam int DefTimeoutClks = 100000;

endpackage

// File: rtl/dcs_rr_pick.sv
// Combinational round-robin selector: first set request bit scanning
// upward from (iLast+1) mod pNumReq.
module dcs_rr_pick #(
   parameter int pNumReq = 4,
   parameter int pIdxW   = 2
) (
   input  logic [pNumReq-1:0] iReq,
   input  logic [pIdxW-1:0]   iLast,
   output logic [pIdxW-1:0]   oIdx,
   output logic               oValid
);

   int w_pos;

   always_comb begin
      oIdx   = '0;
      oValid = 1'b0;
      w_pos  = 0;
      // Offset pNumReq wraps back to iLast itself, so it is considered last.
      for (int i = 1; i <= pNumReq; i++) begin
         w_pos = (int'(iLast) + i) % pNumReq;
         if (!oValid && iReq[pIdxW'(w_pos)]) begin
            oValid = 1'b1;
            oIdx   = pIdxW'(w_pos);
         end
      end
   end

endmodule

// File: rtl/dcs_packet_tx_arb.sv
// Round-robin arbiter feeding one-entry-per-requester packets into a shared
// packet transmitter, with overflow and transfer-timeout reporting.
module dcs_packet_tx_arb
   import dcs_packet_pkg::*;
#(
   parameter int pDataWidth   = DefDataWidth,
   parameter int pNumReq      = 4,
   parameter int pTimeoutClks = DefTimeoutClks
) (
   input  logic                          iClk,
   input  logic                          iRst,
   input  logic [pNumReq-1:0]            iReqStr,
   input  logic [pNumReq*pDataWidth-1:0] iReqData,
   output logic [pNumReq-1:0]            oPending,
   output logic [pNumReq-1:0]            oDoneStr,
   output logic [pNumReq-1:0]            oOvfErrStr,
   output logic                          oTimeoutErrStr,
   output logic [pDataWidth-1:0]         oTxData,
   output logic                          oTxEnStr,
   input  logic                          iTxDoneStr
);

   localparam int IdxW = (pNumReq > 1) ? $clog2(pNumReq) : 1;
   localparam int CntW = $clog2(pTimeoutClks + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(pTimeoutClks - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(pNumReq - 1);

   dcs_state_t            r_state;
   logic [pNumReq-1:0]    r_pending;
   logic [pNumReq-1:0]    r_ovf;
   logic [pDataWidth-1:0] r_buf [pNumReq];
   logic [IdxW-1:0]       r_grant;
   logic [IdxW-1:0]       r_last;
   logic [CntW-1:0]       r_cnt;
   logic [pDataWidth-1:0] r_tx_data;

   logic [IdxW-1:0]       w_pick_idx;
   logic                  w_pick_vld;
   logic [pNumReq-1:0]    w_grant_oh;
   logic [pNumReq-1:0]    w_clr;
   logic                  w_timeout;

   dcs_rr_pick #(
      .pNumReq (pNumReq),
      .pIdxW   (IdxW)
   ) u_rr_pick (
      .iReq   (r_pending),
      .iLast  (r_last),
      .oIdx   (w_pick_idx),
      .oValid (w_pick_vld)
   );

   assign w_grant_oh = pNumReq'(1) << r_grant;
   assign w_clr      = (r_state == StDone) ? w_grant_oh : '0;
   // A done strobe in the final wait cycle wins over the timeout.
   assign w_timeout  = (r_state == StWait) && !iTxDoneStr && (r_cnt == CntLast);

   // Clear-then-set: a strobe in the releasing cycle is accepted, not dropped.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_pending <= '0;
         r_ovf     <= '0;
      end else begin
         for (int k = 0; k < pNumReq; k++) begin
            if (iReqStr[k] && (!r_pending[k] || w_clr[k])) begin
               r_pending[k] <= 1'b1;
            end else if (w_clr[k]) begin
               r_pending[k] <= 1'b0;
            end
            r_ovf[k] <= iReqStr[k] && r_pending[k] && !w_clr[k];
         end
      end
   end

   always_ff @(posedge iClk) begin
      for (int k = 0; k < pNumReq; k++) begin
         if (!iRst && iReqStr[k] && (!r_pending[k] || w_clr[k])) begin
            r_buf[k] <= iReqData[k*pDataWidth +: pDataWidth];
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_state   <= StIdle;
         r_grant   <= '0;
         r_last    <= IdxLast;
         r_cnt     <= '0;
         r_tx_data <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_pick_vld) begin
                  r_grant   <= w_pick_idx;
                  r_tx_data <= r_buf[w_pick_idx];
                  r_state   <= StStart;
               end
            end
            StStart: begin
               r_cnt   <= '0;
               r_state <= StWait;
            end
            StWait: begin
               if (iTxDoneStr || w_timeout) begin
                  r_state <= StDone;
               end else begin
                  r_cnt <= r_cnt + CntW'(1);
               end
            end
            StDone: begin
               r_last  <= r_grant;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   // Outputs are forced low while reset is held, including its first cycle.
   assign oPending       = iRst ? '0 : r_pending;
   assign oOvfErrStr     = iRst ? '0 : r_ovf;
   assign oDoneStr       = (!iRst && (r_state == StDone)) ? w_grant_oh : '0;
   assign oTimeoutErrStr = !iRst && w_timeout;
   assign oTxData        = iRst ? '0 : r_tx_data;
   assign oTxEnStr       = !iRst && (r_state == StStart);

endmodule

// File: doc/dcs_packet_tx_arb.md
DCS_PACKET_TX_ARB -- requirements
Module: dcs_packet_tx_arb

Interface
REQ-001 SHALL have parameter pDataWidth, default 20, packet payload width in bits.
REQ-002 SHALL have parameter pNumReq, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter pTimeoutClks, default 100000, clock cycles allowed from oTxEnStr until iTxDoneStr.
REQ-004 SHALL have port iClk  input  1  system clock; all logic is on the rising edge.
REQ-005 SHALL have port iRst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port iReqStr  input  pNumReq  per-requester one-cycle send strobe.
REQ-007 SHALL have port iReqData  input  pNumReq*pDataWidth  payloads; requester k occupies bits [k*pDataWidth +: pDataWidth].
REQ-008 SHALL have port oPending  output  pNumReq  requester k has a buffered, unfinished packet.
REQ-009 SHALL have port oDoneStr  output  pNumReq  one-cycle completion pulse per requester.
REQ-010 SHALL have port oOvfErrStr  output  pNumReq  one-cycle pulse when a request is dropped.
REQ-011 SHALL have port oTimeoutErrStr  output  1  one-cycle pulse when a transfer times out.
REQ-012 SHALL have port oTxData  output  pDataWidth  payload to the shared packet transmitter.
REQ-013 SHALL have port oTxEnStr  output  1  one-cycle start strobe to the transmitter.
REQ-014 SHALL have port iTxDoneStr  input  1  transmitter completion strobe.

Function
REQ-015 SHALL hold a one-entry buffer per requester; when iReqStr[k] is high and pending[k] is clear, it SHALL capture the slice for k and set pending[k] at the next edge.
REQ-016 SHALL, when iReqStr[k] is high while pending[k] is set and not being cleared that cycle, drop the request, keep the buffered data, and pulse oOvfErrStr[k] on the next cycle.
REQ-017 SHALL, when pending[k] is cleared and iReqStr[k] is high in the same cycle, accept the new request: the clear takes effect first, then the set.
REQ-018 SHALL implement the FSM IDLE -> START -> WAIT -> DONE -> IDLE.
REQ-019 IDLE: if any pending bit is set, SHALL select the first set bit scanning round-robin from (last+1) mod pNumReq, register the grant index, load oTxData, and go to START; otherwise SHALL stay in IDLE.
REQ-020 START: SHALL assert oTxEnStr for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-021 WAIT: SHALL increment the counter each cycle; on iTxDoneStr go to DONE; when the counter reaches pTimeoutClks-1 without done, SHALL pulse oTimeoutErrStr and go to DONE.
REQ-022 DONE: SHALL clear pending[grant], pulse oDoneStr[grant] (also after a timeout), set last=grant, and go to IDLE.
REQ-023 SHALL hold oTxData stable from START through DONE.
REQ-024 SHALL ignore iTxDoneStr outside WAIT.
REQ-025 SHALL give iTxDoneStr priority over the timeout when both occur in the same cycle, with no error pulse.
REQ-026 Latency: for a strobe at edge t with the FSM idle, SHALL assert oTxEnStr in the cycle after edge t+2; back-to-back grants SHALL be separated by IDLE+START only (2 cycles after DONE).
REQ-027 SHALL guarantee fairness: with all requesters continuously pending, grants rotate 0,1,..,pNumReq-1,0.
REQ-028 SHALL size the timeout counter as $clog2(pTimeoutClks+1) bits, with no wrap while in WAIT.

Reset
REQ-029 While iRst is high, SHALL drive FSM=IDLE, pending=0, last=pNumReq-1 (so requester 0 is favoured first), counter=0, oTxData=0, and all strobe outputs=0.
REQ-030 Reset asserted mid-transfer SHALL abandon the transfer with no oDoneStr or error pulse; a later iTxDoneStr SHALL be ignored by REQ-024.
REQ-031 SHALL ignore iReqStr during reset cycles.

Structure
REQ-032 SHALL define the FSM state encoding and the default timeout constant in the shared dcs_packet package, with pDataWidth default matching the tx/rx blocks.
REQ-033 SHALL implement the round-robin selector as sub-module dcs_rr_pick (inputs: request vector, last index; output: grant index and valid), purely combinational.
REQ-034 Top level SHALL connect oTxData/oTxEnStr/iTxDoneStr directly to dcs_packet_tx_v2 iData/iEnStr/oDoneStr, with no glue logic.

Verification
REQ-035 Reset, then iReqStr=4'b0001 with slice0=20'haaaaa -> oTxEnStr 2 cycles later, oTxData=20'haaaaa, then oDoneStr[0] one cycle after the tx done strobe, oPending=0.
REQ-036 Strobe all 4 requesters in the same cycle with data 1,2,3,4 -> oTxData sequence 1,2,3,4, each oDoneStr bit pulsing once, in order.
REQ-037 Second iReqStr[2] while pending[2] is set -> oOvfErrStr[2] pulses and the original data is transmitted unchanged.
REQ-038 pTimeoutClks=50 with the transmitter stub never responding -> oTimeoutErrStr at cycle 50 of WAIT, oDoneStr[k] the next cycle, next grant proceeds.
REQ-039 Assert iRst for 1 cycle during WAIT -> all outputs 0, no done pulse; a stale iTxDoneStr is ignored; a new request is then served normally.
REQ-040 Loopback through dcs_packet_tx_v2/rx_v2 at 115200 baud, 3 requesters -> rx oData matches each payload in round-robin order.
